// File: rtl/ser_lane_scheduler_pkg.sv
// Shared types and default lane constants for the serializer lane scheduler.
package ser_lane_scheduler_pkg;

  localparam int LANE_DATA_W     = 8;
  localparam int LANE_BURST_MAX  = 4;
  localparam int LANE_GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } lane_state_e;

  // Width of a counter holding 0..num_vals-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned num_vals);
    return (num_vals > 1) ? $clog2(num_vals) : 1;
  endfunction

endpackage

// File: rtl/ser_lane_scheduler_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_o
);

  // Walk the requests cyclically from the pointer and keep the first hit.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        grant_o = ID_W'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_lane_scheduler.sv
// Round-robin scheduler sharing one parallel-in/serial-out lane between
// several pattern sources: bursts of words per grant, then a gap.
module ser_lane_scheduler
  import ser_lane_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = LANE_DATA_W,
  parameter int BURST_MAX  = LANE_BURST_MAX,
  parameter int GAP_CYCLES = LANE_GAP_CYCLES,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      t_clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ser_load,
  output logic [DATA_W-1:0]         ser_data,
  output logic [ID_W-1:0]           ser_src_id,
  output logic                      busy
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam int WC_W  = cnt_width(BURST_MAX + 1);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(BURST_MAX);

  lane_state_e        state_q,    state_d;
  logic [ID_W-1:0]    grant_q,    grant_d;
  logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic               last_q,     last_d;
  logic               ser_load_q, ser_load_d;
  logic [DATA_W-1:0]  ser_data_q, ser_data_d;
  logic [ID_W-1:0]    src_id_q,   src_id_d;

  logic [ID_W-1:0]    arb_grant;
  logic               arb_any;
  logic [NUM_REQ-1:0] ready_c;
  logic               accept;
  logic               go_gap;
  logic               burst_cont;
  logic [DATA_W-1:0]  grant_word;
  logic [ID_W-1:0]    next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  assign grant_word = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign next_ptr   = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_W'(1);
  assign burst_cont = !last_q && (word_cnt_q < WC_MAX) && enable;

  // Next-state, handshake and lane-register updates for the scheduler FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_d     = last_q;
    ser_load_d = 1'b0;
    ser_data_d = ser_data_q;
    src_id_d   = src_id_q;
    ready_c    = '0;
    accept     = 1'b0;
    go_gap     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && arb_any) begin
          grant_d = arb_grant;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready_c[grant_q] = 1'b1;
        if (req_valid[grant_q]) accept = 1'b1;
        else                    go_gap = 1'b1;
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          if (burst_cont) begin
            ready_c[grant_q] = 1'b1;
            if (req_valid[grant_q]) accept = 1'b1;
            else                    go_gap = 1'b1;
          end else begin
            go_gap = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d  = ST_IDLE;
          src_id_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word accepted: launch it to the serializer on the next edge.
    if (accept) begin
      state_d    = ST_SHIFT;
      ser_load_d = 1'b1;
      ser_data_d = grant_word;
      src_id_d   = grant_q;
      last_d     = req_last[grant_q];
      bit_cnt_d  = '0;
      word_cnt_d = (state_q == ST_LOAD) ? WC_W'(1) : word_cnt_q + WC_W'(1);
    end

    // Burst over: release the grant and advance the round-robin pointer.
    if (go_gap) begin
      state_d    = ST_GAP;
      gap_cnt_d  = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      ser_data_d = '0;
      rr_ptr_d   = next_ptr;
    end
  end

  // State and lane registers; reset aborts any word in flight.
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b0;
      ser_load_q <= 1'b0;
      ser_data_q <= '0;
      src_id_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      ser_load_q <= ser_load_d;
      ser_data_q <= ser_data_d;
      src_id_q   <= src_id_d;
    end
  end

  assign req_ready  = ready_c;
  assign ser_load   = ser_load_q;
  assign ser_data   = ser_data_q;
  assign ser_src_id = src_id_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_ser_lane_scheduler.sv
// Self-checking bench: per-source word queues drive the DUT; a transaction-level
// round-robin/burst model predicts the ordered words on the lane and their spacing.
module tb_ser_lane_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int BURST_MAX  = 4;
  localparam int GAP_CYCLES = 1;
  localparam int ID_W       = $clog2(NUM_REQ);
  localparam int IN_BURST   = DATA_W;
  localparam int NEW_BURST  = DATA_W + GAP_CYCLES + 2;

  typedef struct packed { logic [DATA_W-1:0] data; logic last; } word_t;
  typedef struct { int src; logic [DATA_W-1:0] data; int gap; } exp_t;

  logic                      t_clk = 1'b0;
  logic                      rst_n;
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ser_load;
  logic [DATA_W-1:0]         ser_data;
  logic [ID_W-1:0]           ser_src_id;
  logic                      busy;

  word_t src_q[NUM_REQ][$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int sl = 100;
  int loads = 0;
  int model_ptr = 0;
  int cur_src = 0;
  logic [DATA_W-1:0] cur_data = '0;
  int ready_cnt[NUM_REQ];

  ser_lane_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .BURST_MAX  (BURST_MAX),
    .GAP_CYCLES (GAP_CYCLES),
    .ID_W       (ID_W)
  ) dut (
    .t_clk      (t_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .ser_load   (ser_load),
    .ser_data   (ser_data),
    .ser_src_id (ser_src_id),
    .busy       (busy)
  );

  always #5 t_clk = ~t_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input int s, input logic [DATA_W-1:0] d, input logic l);
    src_q[s].push_back('{data: d, last: l});
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                 = (src_q[i].size() != 0);
      req_data[i*DATA_W +: DATA_W] = (src_q[i].size() != 0) ? src_q[i][0].data : '0;
      req_last[i]                  = (src_q[i].size() != 0) ? src_q[i][0].last : 1'b0;
    end
  endtask

  task automatic clear_ready_cnt();
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
  endtask

  // Transaction model: sources holding words are served round-robin from the
  // pointer; a burst ends on a last word, after BURST_MAX words, or when the
  // source runs dry. Spacing: one word period inside a burst, plus the gap,
  // idle and load cycles between bursts.
  task automatic plan();
    word_t m[NUM_REQ][$];
    word_t w;
    bit    first;
    bit    found;
    int    g;
    int    n;
    for (int i = 0; i < NUM_REQ; i++) m[i] = src_q[i];
    first = 1'b1;
    for (int b = 0; b < 200; b++) begin
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && m[(model_ptr + k) % NUM_REQ].size() != 0) begin
          found = 1'b1;
          g     = (model_ptr + k) % NUM_REQ;
        end
      end
      if (found) begin
        n = 0;
        while (m[g].size() != 0 && n < BURST_MAX) begin
          w = m[g].pop_front();
          exp_q.push_back('{src: g, data: w.data,
                            gap: first ? 0 : ((n == 0) ? NEW_BURST : IN_BURST)});
          first = 1'b0;
          n++;
          if (w.last) break;
        end
        model_ptr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  // Checks made on every sampled cycle (negedge, away from the active edge).
  task automatic observe();
    exp_t e;
    check("ready_onehot", 32'($onehot0(req_ready)), 1);
    if (req_ready != '0) check("busy_when_ready", busy, 1);
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
    if (ser_load) begin
      check("load_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("load_src", ser_src_id, e.src);
        check("load_data", ser_data, e.data);
        check("load_busy", busy, 1);
        if (e.gap != 0) check("load_interval", cyc - last_load_cyc, e.gap);
        cur_src  = e.src;
        cur_data = e.data;
      end
      last_load_cyc = cyc;
      sl = 0;
      loads++;
    end else begin
      if (sl < 100) sl++;
      if (sl >= 1 && sl <= DATA_W - 1) begin
        check("word_busy", busy, 1);
        check("word_src_hold", ser_src_id, cur_src);
        check("word_data_hold", ser_data, cur_data);
      end else if (sl == DATA_W) begin
        check("gap_busy", busy, 0);
        check("gap_data", ser_data, 0);
        check("gap_src_hold", ser_src_id, cur_src);
      end else if (sl == DATA_W + GAP_CYCLES) begin
        check("idle_busy", busy, 0);
        check("idle_src", ser_src_id, 0);
      end
    end
  endtask

  // One clock: sample at negedge, then pop accepted words just after posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    @(negedge t_clk);
    observe();
    hs = req_ready & req_valid;
    @(posedge t_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive_sources();
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (DATA_W + 6) tick();
  endtask

  task automatic run_plan(input int budget);
    drive_sources();
    plan();
    drain(budget);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    drive_sources();
    clear_ready_cnt();
    repeat (3) @(posedge t_clk);
    #2;
    check("rst_load", ser_load, 0);
    check("rst_data", ser_data, 0);
    check("rst_src", ser_src_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(negedge t_clk);
    rst_n  = 1'b1;
    @(posedge t_clk);
    #1;
    enable = 1'b1;

    // Reset mid-word: 0x5A in flight is aborted, all outputs drop at once.
    add_word(0, 8'h5A, 1'b1);
    drive_sources();
    plan();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("pre_reset_load_seen", exp_q.size(), 0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_load", ser_load, 0);
    check("async_rst_data", ser_data, 0);
    check("async_rst_src", ser_src_id, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", req_ready, 0);
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    model_ptr = 0;
    sl = 100;
    drive_sources();
    @(negedge t_clk);
    rst_n = 1'b1;

    // All four valid after reset: grants start at source 0.
    for (int i = 0; i < NUM_REQ; i++) add_word(i, 8'(8'hC0 + i), 1'b1);
    run_plan(200);

    // Single word from source 0: ready for exactly one cycle.
    clear_ready_cnt();
    add_word(0, 8'hA5, 1'b1);
    run_plan(100);
    check("single_ready_cnt", ready_cnt[0], 1);

    // Three-word burst from source 1, back-to-back loads.
    clear_ready_cnt();
    add_word(1, 8'h12, 1'b0);
    add_word(1, 8'h69, 1'b0);
    add_word(1, 8'hFF, 1'b1);
    run_plan(150);
    check("burst_ready_cnt", ready_cnt[1], 3);

    // Fairness between sources 0 and 2; 1 and 3 are never offered ready.
    clear_ready_cnt();
    for (int j = 0; j < 4; j++) begin
      add_word(0, 8'(8'h30 + j), 1'b1);
      add_word(2, 8'(8'h40 + j), 1'b1);
    end
    run_plan(300);
    check("fair_ready_src1", ready_cnt[1], 0);
    check("fair_ready_src3", ready_cnt[3], 0);

    // Burst cap: six unterminated words from source 3 split 4 + 2.
    clear_ready_cnt();
    for (int j = 1; j <= 6; j++) add_word(3, 8'(j), 1'b0);
    run_plan(300);
    check("cap_ready_cnt", ready_cnt[3], 7);

    // Enable dropped during word 2 of 3: word 2 completes, word 3 waits.
    clear_ready_cnt();
    add_word(2, 8'h31, 1'b0);
    add_word(2, 8'h32, 1'b0);
    add_word(2, 8'h33, 1'b1);
    drive_sources();
    exp_q.push_back('{src: 2, data: 8'h31, gap: 0});
    exp_q.push_back('{src: 2, data: 8'h32, gap: IN_BURST});
    n = loads + 2;
    while (loads < n && exp_q.size() != 0 && cyc < 100000) tick();
    enable = 1'b0;
    repeat (3 * DATA_W) tick();
    check("en_drop_ready_cnt", ready_cnt[2], 2);
    check("en_drop_busy", busy, 0);
    check("en_drop_ready", req_ready, 0);
    check("en_drop_pending", src_q[2].size(), 1);
    model_ptr = 3;
    enable = 1'b1;
    exp_q.push_back('{src: 2, data: 8'h33, gap: 0});
    drain(100);

    // Randomized traffic against the transaction model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++)
          add_word(i, 8'($urandom), ($urandom_range(0, 2) == 0));
      end
      run_plan(800);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
